// File: rtl/vproc_pkg.sv
// Shared vector-unit constants and helpers used by the divide result packer.
package vproc_pkg;

    localparam int unsigned VREG_ADDR_W = 5;
    localparam int unsigned NUM_VREGS   = 32;

    // A single-chunk configuration still needs a 1-bit counter to stay legal.
    function automatic int unsigned chunk_cnt_width(input int unsigned chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/vproc_div_res_pack.sv
// Packs DIV_OP_W-wide divider result chunks into VREG_W-wide register-file writes.
module vproc_div_res_pack
    import vproc_pkg::*;
#(
    parameter int unsigned DIV_OP_W       = 64,
    parameter int unsigned VREG_W         = 256,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     async_rst_ni,
    input  logic                     sync_rst_ni,

    input  logic                     pipe_in_valid_i,
    output logic                     pipe_in_ready_o,
    input  logic [VREG_ADDR_W-1:0]   pipe_in_vd_i,
    input  logic                     pipe_in_last_i,
    input  logic [DIV_OP_W-1:0]      pipe_in_res_i,
    input  logic [DIV_OP_W/8-1:0]    pipe_in_mask_i,

    output logic                     vreg_wr_valid_o,
    input  logic                     vreg_wr_ready_i,
    output logic [VREG_ADDR_W-1:0]   vreg_wr_addr_o,
    output logic [VREG_W-1:0]        vreg_wr_data_o,
    output logic [VREG_W/8-1:0]      vreg_wr_be_o,

    output logic                     busy_o,
    output logic [NUM_VREGS-1:0]     pend_vd_o
);

    localparam int unsigned CHUNKS = VREG_W / DIV_OP_W;
    localparam int unsigned CNT_W  = chunk_cnt_width(CHUNKS);
    localparam int unsigned BE_W   = DIV_OP_W / 8;
    localparam int unsigned VBE_W  = VREG_W / 8;

    localparam logic [DIV_OP_W-1:0] FILL = DONT_CARE_ZERO ? {DIV_OP_W{1'b0}} : {DIV_OP_W{1'bx}};

    typedef struct packed {
        logic [VREG_ADDR_W-1:0] addr;
        logic [VREG_W-1:0]      data;
        logic [VBE_W-1:0]       be;
    } vreg_wr_t;

    logic [CNT_W-1:0]       cnt_q;
    logic [VREG_ADDR_W-1:0] buf_vd_q;
    logic [VREG_W-1:0]      buf_data_q;
    logic [VBE_W-1:0]       buf_be_q;
    vreg_wr_t               out_q;
    logic                   out_valid_q;

    logic [31:0]            cnt_ext;
    logic                   buf_nonempty;
    logic                   out_free;
    logic                   vd_mismatch;
    logic                   completes;
    logic                   accept;
    logic                   flush;
    logic                   load_out;
    vreg_wr_t               word;

    // Handshakes: a transfer happens on a clock edge where valid and ready are both high;
    // valid never depends on ready, and the write-port payload is held while valid & !ready.
    assign cnt_ext      = 32'(cnt_q);
    assign buf_nonempty = (cnt_q != '0);
    assign out_free     = !out_valid_q || vreg_wr_ready_i;
    assign vd_mismatch  = buf_nonempty && (pipe_in_vd_i != buf_vd_q);
    assign completes    = (cnt_q == CNT_W'(CHUNKS - 1)) || pipe_in_last_i;

    assign pipe_in_ready_o = !vd_mismatch && (!completes || out_free);
    assign accept          = pipe_in_valid_i && pipe_in_ready_o;
    // A chunk for a different register pushes the partial word out ahead of it.
    assign flush           = pipe_in_valid_i && vd_mismatch && out_free;
    assign load_out        = (accept && completes) || flush;

    // Word presented to the output register: buffered slots, the incoming chunk when it
    // is being accepted, and filler for anything not yet written.
    always_comb begin
        word      = '0;
        word.addr = buf_nonempty ? buf_vd_q : pipe_in_vd_i;
        for (int unsigned s = 0; s < CHUNKS; s++) begin
            if (s < cnt_ext) begin
                word.data[s*DIV_OP_W +: DIV_OP_W] = buf_data_q[s*DIV_OP_W +: DIV_OP_W];
                word.be[s*BE_W +: BE_W]           = buf_be_q[s*BE_W +: BE_W];
            end else if ((s == cnt_ext) && !vd_mismatch) begin
                word.data[s*DIV_OP_W +: DIV_OP_W] = pipe_in_res_i;
                word.be[s*BE_W +: BE_W]           = pipe_in_mask_i;
            end else begin
                word.data[s*DIV_OP_W +: DIV_OP_W] = FILL;
            end
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            cnt_q       <= '0;
            buf_vd_q    <= '0;
            buf_be_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (!sync_rst_ni) begin
            cnt_q       <= '0;
            buf_vd_q    <= '0;
            buf_be_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && vreg_wr_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (load_out) begin
                out_valid_q <= 1'b1;
                cnt_q       <= '0;
                buf_be_q    <= '0;
            end else if (accept) begin
                cnt_q                          <= cnt_q + CNT_W'(1);
                buf_be_q[cnt_ext*BE_W +: BE_W] <= pipe_in_mask_i;
                if (!buf_nonempty) begin
                    buf_vd_q <= pipe_in_vd_i;
                end
            end
        end
    end

    // Payload registers carry no reset; the control flags above qualify them.
    always_ff @(posedge clk_i) begin
        if (load_out) begin
            out_q <= word;
        end else if (accept) begin
            buf_data_q[cnt_ext*DIV_OP_W +: DIV_OP_W] <= pipe_in_res_i;
        end
    end

    assign vreg_wr_valid_o = out_valid_q;
    assign vreg_wr_addr_o  = out_q.addr;
    assign vreg_wr_data_o  = out_q.data;
    assign vreg_wr_be_o    = out_q.be;

    always_comb begin
        pend_vd_o = '0;
        if (buf_nonempty) begin
            pend_vd_o[buf_vd_q] = 1'b1;
        end
        if (out_valid_q) begin
            pend_vd_o[out_q.addr] = 1'b1;
        end
    end

    assign busy_o = |pend_vd_o;

endmodule

// File: tb/tb_vproc_div_res_pack.sv
// Directed scoreboard bench for the divide result packer (64-bit chunks, 256-bit words).
module tb_vproc_div_res_pack;

    localparam int DW = 64;
    localparam int VW = 256;
    localparam int EW = 5 + VW + VW / 8;

    logic            clk_i = 1'b0;
    logic            async_rst_ni;
    logic            sync_rst_ni;
    logic            pipe_in_valid_i;
    logic            pipe_in_ready_o;
    logic [4:0]      pipe_in_vd_i;
    logic            pipe_in_last_i;
    logic [DW-1:0]   pipe_in_res_i;
    logic [DW/8-1:0] pipe_in_mask_i;
    logic            vreg_wr_valid_o;
    logic            vreg_wr_ready_i;
    logic [4:0]      vreg_wr_addr_o;
    logic [VW-1:0]   vreg_wr_data_o;
    logic [VW/8-1:0] vreg_wr_be_o;
    logic            busy_o;
    logic [31:0]     pend_vd_o;

    int tests  = 0;
    int fails  = 0;
    int writes = 0;
    logic [EW-1:0] exp_q[$];

    vproc_div_res_pack #(
        .DIV_OP_W       (DW),
        .VREG_W         (VW),
        .DONT_CARE_ZERO (1'b1)
    ) dut (
        .clk_i           (clk_i),
        .async_rst_ni    (async_rst_ni),
        .sync_rst_ni     (sync_rst_ni),
        .pipe_in_valid_i (pipe_in_valid_i),
        .pipe_in_ready_o (pipe_in_ready_o),
        .pipe_in_vd_i    (pipe_in_vd_i),
        .pipe_in_last_i  (pipe_in_last_i),
        .pipe_in_res_i   (pipe_in_res_i),
        .pipe_in_mask_i  (pipe_in_mask_i),
        .vreg_wr_valid_o (vreg_wr_valid_o),
        .vreg_wr_ready_i (vreg_wr_ready_i),
        .vreg_wr_addr_o  (vreg_wr_addr_o),
        .vreg_wr_data_o  (vreg_wr_data_o),
        .vreg_wr_be_o    (vreg_wr_be_o),
        .busy_o          (busy_o),
        .pend_vd_o       (pend_vd_o)
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic push_exp(input logic [4:0] addr, input logic [VW-1:0] data, input logic [VW/8-1:0] be);
        exp_q.push_back({addr, data, be});
    endtask

    // Scoreboard: every completed write-port transfer is popped and compared in order.
    always @(negedge clk_i) begin
        if (async_rst_ni && vreg_wr_valid_o && vreg_wr_ready_i) begin
            logic [EW-1:0] e;
            writes++;
            check("write_expected", VW'(exp_q.size() != 0), VW'(1'b1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", VW'(vreg_wr_addr_o), VW'(e[EW-1 -: 5]));
                check("wr_data", vreg_wr_data_o, e[VW/8 +: VW]);
                check("wr_be", VW'(vreg_wr_be_o), VW'(e[VW/8-1:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one chunk from posedge+1 and returns at posedge+1 after it was accepted.
    task automatic send(input logic [4:0] vd, input logic [DW-1:0] res, input logic [7:0] mask,
                        input logic last, output int stalls);
        pipe_in_valid_i = 1'b1;
        pipe_in_vd_i    = vd;
        pipe_in_res_i   = res;
        pipe_in_mask_i  = mask;
        pipe_in_last_i  = last;
        stalls = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (pipe_in_ready_o) break;
            stalls++;
        end
        if (!pipe_in_ready_o) check("accept_timeout", VW'(pipe_in_ready_o), VW'(1'b1));
        tick();
        pipe_in_valid_i = 1'b0;
        pipe_in_last_i  = 1'b0;
    endtask

    initial begin
        int st;
        int tot;
        int w0;
        async_rst_ni    = 1'b0;
        sync_rst_ni     = 1'b1;
        pipe_in_valid_i = 1'b0;
        pipe_in_vd_i    = '0;
        pipe_in_last_i  = 1'b0;
        pipe_in_res_i   = '0;
        pipe_in_mask_i  = '0;
        vreg_wr_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 async_rst_ni = 1'b1;
        tick();

        check("rst_valid", VW'(vreg_wr_valid_o), VW'(1'b0));
        check("rst_busy", VW'(busy_o), VW'(1'b0));
        check("rst_pend", VW'(pend_vd_o), VW'(32'h0));
        check("rst_ready", VW'(pipe_in_ready_o), VW'(1'b1));

        // Full word to v3
        push_exp(5'd3, {rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)}, {32{1'b1}});
        send(5'd3, rep(8'h11), 8'hFF, 1'b0, st);
        send(5'd3, rep(8'h22), 8'hFF, 1'b0, st);
        check("t1_pend_partial", VW'(pend_vd_o), VW'(32'h8));
        check("t1_busy_partial", VW'(busy_o), VW'(1'b1));
        send(5'd3, rep(8'h33), 8'hFF, 1'b0, st);
        send(5'd3, rep(8'h44), 8'hFF, 1'b1, st);
        check("t1_latency_valid", VW'(vreg_wr_valid_o), VW'(1'b1));
        check("t1_pend_out", VW'(pend_vd_o), VW'(32'h8));
        tick();
        check("t1_idle_busy", VW'(busy_o), VW'(1'b0));

        // Early last with partial mask; upper half zero-filled
        push_exp(5'd5, {128'h0, rep(8'hBB), rep(8'hAA)}, 32'h0000_0FFF);
        send(5'd5, rep(8'hAA), 8'hFF, 1'b0, st);
        send(5'd5, rep(8'hBB), 8'h0F, 1'b1, st);
        tick();

        // Destination change flushes the partial word
        push_exp(5'd2, {192'h0, rep(8'hCC)}, 32'h0000_00FF);
        push_exp(5'd7, {rep(8'hD4), rep(8'hD3), rep(8'hD2), rep(8'hD1)}, {32{1'b1}});
        send(5'd2, rep(8'hCC), 8'hFF, 1'b0, st);
        send(5'd7, rep(8'hD1), 8'hFF, 1'b0, st);
        check("t3_mismatch_stall", VW'(st), VW'(1));
        check("t3_pend_new_vd", VW'(pend_vd_o), VW'(32'h80));
        send(5'd7, rep(8'hD2), 8'hFF, 1'b0, st);
        send(5'd7, rep(8'hD3), 8'hFF, 1'b0, st);
        send(5'd7, rep(8'hD4), 8'hFF, 1'b0, st);
        tick();

        // Write port back-pressure
        vreg_wr_ready_i = 1'b0;
        push_exp(5'd4, {rep(8'hE4), rep(8'hE3), rep(8'hE2), rep(8'hE1)}, {32{1'b1}});
        push_exp(5'd6, {rep(8'hF4), rep(8'hF3), rep(8'hF2), rep(8'hF1)}, {32{1'b1}});
        send(5'd4, rep(8'hE1), 8'hFF, 1'b0, st);
        send(5'd4, rep(8'hE2), 8'hFF, 1'b0, st);
        send(5'd4, rep(8'hE3), 8'hFF, 1'b0, st);
        send(5'd4, rep(8'hE4), 8'hFF, 1'b0, st);
        check("t4_out_valid", VW'(vreg_wr_valid_o), VW'(1'b1));
        tot = 0;
        send(5'd6, rep(8'hF1), 8'hFF, 1'b0, st); tot += st;
        send(5'd6, rep(8'hF2), 8'hFF, 1'b0, st); tot += st;
        send(5'd6, rep(8'hF3), 8'hFF, 1'b0, st); tot += st;
        check("t4_noncompleting_stalls", VW'(tot), VW'(0));
        pipe_in_valid_i = 1'b1;
        pipe_in_vd_i    = 5'd6;
        pipe_in_res_i   = rep(8'hF4);
        pipe_in_mask_i  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("t4_completing_stalls", VW'(pipe_in_ready_o), VW'(1'b0));
            check("t4_addr_hold", VW'(vreg_wr_addr_o), VW'(5'd4));
            check("t4_data_hold", vreg_wr_data_o, {rep(8'hE4), rep(8'hE3), rep(8'hE2), rep(8'hE1)});
            tick();
        end
        check("t4_pend_both", VW'(pend_vd_o), VW'(32'h50));
        vreg_wr_ready_i = 1'b1;
        send(5'd6, rep(8'hF4), 8'hFF, 1'b0, st);
        check("t4_release_stall", VW'(st), VW'(0));
        check("t4_no_bubble_valid", VW'(vreg_wr_valid_o), VW'(1'b1));
        check("t4_no_bubble_addr", VW'(vreg_wr_addr_o), VW'(5'd6));
        tick();

        // Async reset mid-accumulation
        send(5'd9, rep(8'h55), 8'hFF, 1'b0, st);
        send(5'd9, rep(8'h66), 8'hFF, 1'b0, st);
        async_rst_ni = 1'b0;
        #1;
        check("t5_async_busy", VW'(busy_o), VW'(1'b0));
        check("t5_async_pend", VW'(pend_vd_o), VW'(32'h0));
        check("t5_async_valid", VW'(vreg_wr_valid_o), VW'(1'b0));
        #2 async_rst_ni = 1'b1;
        tick();
        push_exp(5'd10, {rep(8'h74), rep(8'h73), rep(8'h72), rep(8'h71)}, {32{1'b1}});
        send(5'd10, rep(8'h71), 8'hFF, 1'b0, st);
        send(5'd10, rep(8'h72), 8'hFF, 1'b0, st);
        send(5'd10, rep(8'h73), 8'hFF, 1'b0, st);
        send(5'd10, rep(8'h74), 8'hFF, 1'b0, st);
        tick();

        // Sync reset mid-accumulation
        send(5'd11, rep(8'h99), 8'hFF, 1'b0, st);
        sync_rst_ni = 1'b0;
        tick();
        sync_rst_ni = 1'b1;
        check("t5_sync_pend", VW'(pend_vd_o), VW'(32'h0));
        push_exp(5'd12, {128'h0, rep(8'hA2), rep(8'hA1)}, 32'h0000_FFFF);
        send(5'd12, rep(8'hA1), 8'hFF, 1'b0, st);
        send(5'd12, rep(8'hA2), 8'hFF, 1'b1, st);
        tick();

        // Continuous stream of two words
        w0  = writes;
        tot = 0;
        push_exp(5'd1, {rep(8'h13), rep(8'h12), rep(8'h11), rep(8'h10)}, {32{1'b1}});
        push_exp(5'd2, {rep(8'h17), rep(8'h16), rep(8'h15), rep(8'h14)}, {32{1'b1}});
        for (int i = 0; i < 8; i++) begin
            send((i < 4) ? 5'd1 : 5'd2, rep(8'(8'h10 + i)), 8'hFF, 1'b0, st);
            tot += st;
            if (i == 1) check("t6_pend_vd1", VW'(pend_vd_o), VW'(32'h2));
            if (i == 5) check("t6_pend_vd2", VW'(pend_vd_o), VW'(32'h4));
        end
        tick();
        tick();
        check("t6_stream_stalls", VW'(tot), VW'(0));
        check("t6_write_count", VW'(writes - w0), VW'(2));

        repeat (3) tick();
        check("exp_q_drained", VW'(exp_q.size()), VW'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vproc_div_res_pack.md
Name: vproc_div_res_pack

Overview:
Write-back packer on the result side of the vector divide unit. It consumes the DIV_OP_W-wide result/mask stream from the divider's output handshake and accumulates consecutive chunks into a full VREG_W-wide vector register word with byte enables. It issues one register-file write per completed (or flushed) word over a valid/ready write port. It sits between the divide pipeline output and the vector register file write arbiter.

Parameters:
DIV_OP_W, 64, width in bits of one incoming result chunk; a multiple of 32.
VREG_W, 256, vector register width in bits; VREG_W/DIV_OP_W (CHUNKS) is a power of two, ≥1.
DONT_CARE_ZERO, 1'b0, drive '0 instead of 'x on don't-care data bits.

Ports:
clk_i  in  1  clock
async_rst_ni  in  1  asynchronous active-low reset
sync_rst_ni  in  1  synchronous active-low reset
pipe_in_valid_i  in  1  result chunk valid
pipe_in_ready_o  out  1  chunk accepted when valid&ready
pipe_in_vd_i  in  5  destination vector register of the chunk
pipe_in_last_i  in  1  final chunk of the instruction; forces a write
pipe_in_res_i  in  DIV_OP_W  result data
pipe_in_mask_i  in  DIV_OP_W/8  per-byte write mask (already vl/v0 masked)
vreg_wr_valid_o  out  1  write request
vreg_wr_ready_i  in  1  write accepted when valid&ready
vreg_wr_addr_o  out  5  destination register
vreg_wr_data_o  out  VREG_W  write data
vreg_wr_be_o  out  VREG_W/8  byte enables
busy_o  out  1  accumulation buffer non-empty or write pending
pend_vd_o  out  32  one-hot of registers with buffered or pending data

Behaviour:
- Reset is async_rst_ni, asynchronous, active-low; clock is clk_i. sync_rst_ni low at a clock edge has the same effect as async reset.
- Reset values: vreg_wr_valid_o=0, busy_o=0, pend_vd_o=0. The slot counter and the accumulated byte enables clear to 0. Reset mid-accumulation discards the partial data and issues no write.
- State: accumulation buffer with slot counter cnt (log2 CHUNKS bits, 0 when empty), buffered vd, and data/be registers. Output register holds addr/data/be and a valid flag.
- The output register is free when it is not valid, or when vreg_wr_ready_i=1 in the same cycle.
- Each accepted chunk writes data/mask into slot cnt: bits [DIV_OP_W*cnt +: DIV_OP_W], be [DIV_OP_W/8*cnt +: DIV_OP_W/8]. Slot 0 is the least significant.
- On acceptance at cnt=0, the buffered vd is taken from pipe_in_vd_i.
- A chunk completes a word if cnt==CHUNKS-1 or pipe_in_last_i=1.
  - Completing chunk: accepted only if the output register is free. On acceptance, the buffer plus this chunk move to the output register in the same cycle. cnt returns to 0 and the accumulated be clears.
  - Non-completing chunk: always accepted, and cnt increments.
- vd mismatch (cnt≠0 and pipe_in_vd_i≠buffered vd):
  - pipe_in_ready_o=0 that cycle.
  - If the output register is free, the partial buffer moves to the output register (unfilled slots be=0) and cnt returns to 0.
  - The chunk is then accepted at slot 0 on a later cycle.
- Unfilled slot data is don't-care, or '0 when DONT_CARE_ZERO.
- Latency: vreg_wr_valid_o rises the cycle after the completing chunk is accepted.
- Output handshake: addr/data/be are held stable while valid&!ready.
- Sustained throughput: one chunk per cycle; back-to-back words have no bubble when vreg_wr_ready_i=1.
- CHUNKS=1: every chunk completes.
- pend_vd_o bits are set for the buffered vd when cnt≠0 and for the output addr when the output is valid. The two bits OR together when they name the same register.
- busy_o = |pend_vd_o.

Decomposition:
- Add to vproc_pkg a packed struct vreg_wr_t {addr[4:0], data, be}, parameterised by width via localparams in the module.
- No sub-module: the counter, buffer and output register are a single block.

Test Plan:
All scenarios use DIV_OP_W=64, VREG_W=256 with vreg_wr_ready_i=1 unless noted.
- 4 chunks to vd=3, res=64'h11..,22..,33..,44.., mask=8'hFF, last on the 4th → one write: addr 3, data {44..,33..,22..,11..}, be all ones, valid 1 cycle after the 4th acceptance.
- 2 chunks to vd=5, last on the 2nd, masks FF and 0F → write: be = 32'h0000_0FFF, upper 128 data bits 0 with DONT_CARE_ZERO=1.
- vd=2 chunk then vd=7 chunk → ready=0 for one cycle, write to vd 2 with be=32'h0000_00FF, then vd=7 is accepted at slot 0.
- Hold vreg_wr_ready_i=0 with a write pending: 3 further non-completing chunks are accepted and the 4th stalls (ready=0). Addr/data stay stable. After ready=1 the next write follows with no bubble.
- Assert async_rst_ni after 2 chunks: busy_o=0 and pend_vd_o=0 immediately. A following 4-chunk sequence writes only new data.
- Continuous 8-chunk stream to vd=1 then vd=2, ready tied 1 → exactly 2 writes, pipe_in_ready_o stays high throughout, pend_vd_o shows bits 1 then 2.
